// File: rtl/romcode_arb_pkg.sv
// Shared types and constants for the romcode BRAM arbiter.
package romcode_arb_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int STRB_W      = DATA_W / 8;
    localparam int BRAM_RD_LAT = 1;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_RD   = 2'd1,
        G_WR   = 2'd2
    } grant_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/romcode_arb_rdpipe.sv
// Read-return pipeline: tracks accepted reads through the BRAM latency and
// captures the returned word when it lands.
module romcode_arb_rdpipe
    import romcode_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_accept,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata
);

    // One stage for the registered BRAM drivers, plus the BRAM read latency.
    localparam int PIPE_D = BRAM_RD_LAT + 1;

    logic [PIPE_D-1:0] rd_pipe_d, rd_pipe_q;
    logic              rvalid_d, rvalid_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_comb begin
        rd_pipe_d = {rd_pipe_q[PIPE_D-2:0], rd_accept};
        rvalid_d  = rd_pipe_q[PIPE_D-1];
        rdata_d   = rvalid_d ? bram_dout : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rd_rvalid = rvalid_q;
    assign rd_rdata  = rdata_q;

endmodule

// File: rtl/romcode_bram_arb.sv
// Single-port romcode BRAM arbiter: reads have priority, the loader is
// guaranteed a slot after MAX_WAIT consecutive refusals.
module romcode_bram_arb
    import romcode_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              rom_lock,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic [STRB_W-1:0] bram_wen,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    logic [ADDR_W-1:0] bram_addr_d, bram_addr_q;
    logic              bram_en_d,   bram_en_q;
    logic [STRB_W-1:0] bram_wen_d,  bram_wen_q;
    logic [DATA_W-1:0] bram_din_d,  bram_din_q;
    logic [WAIT_W-1:0] wait_cnt_d,  wait_cnt_q;
    grant_e            last_gnt_d,  last_gnt_q;

    logic force_wr;
    logic rd_acc;
    logic wr_acc;

    // Grants are gated by reset so nothing can be accepted while held in reset.
    always_comb begin
        force_wr = wr_valid & ~rom_lock & (wait_cnt_q == WAIT_W'(MAX_WAIT));
        rd_gnt   = ap_rst_n & rd_req & ~force_wr;
        wr_ready = ap_rst_n & ~rom_lock & (~rd_req | force_wr);
        rd_acc   = rd_req & rd_gnt;
        wr_acc   = wr_valid & wr_ready;
    end

    always_comb begin
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_en_d   = 1'b0;
        bram_wen_d  = '0;
        last_gnt_d  = G_NONE;
        if (rd_acc) begin
            bram_en_d   = 1'b1;
            bram_addr_d = word_align(rd_addr);
            last_gnt_d  = G_RD;
        end else if (wr_acc) begin
            last_gnt_d = G_WR;
            // An all-zero strobe is accepted but never touches the BRAM.
            if (|wr_strb) begin
                bram_en_d   = 1'b1;
                bram_wen_d  = wr_strb;
                bram_addr_d = word_align(wr_addr);
                bram_din_d  = wr_data;
            end
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wr_acc || !wr_valid || rom_lock) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            bram_addr_q <= '0;
            bram_en_q   <= 1'b0;
            bram_wen_q  <= '0;
            bram_din_q  <= '0;
            wait_cnt_q  <= '0;
            last_gnt_q  <= G_NONE;
        end else begin
            bram_addr_q <= bram_addr_d;
            bram_en_q   <= bram_en_d;
            bram_wen_q  <= bram_wen_d;
            bram_din_q  <= bram_din_d;
            wait_cnt_q  <= wait_cnt_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    assign bram_addr = bram_addr_q;
    assign bram_en   = bram_en_q;
    assign bram_wen  = bram_wen_q;
    assign bram_din  = bram_din_q;

    // last_gnt_q is a debug probe with no functional reader.
    logic [1:0] unused_dbg;
    assign unused_dbg = last_gnt_q;

    romcode_arb_rdpipe u_rdpipe (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .rd_accept (rd_acc),
        .bram_dout (bram_dout),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata)
    );

endmodule

// File: tb/tb_romcode_bram_arb.sv
// Directed self-checking bench for romcode_bram_arb with a read-first BRAM model.
module tb_romcode_bram_arb;
    import romcode_arb_pkg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic        rd_rvalid;
    logic [31:0] rd_rdata;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rom_lock;
    logic [31:0] bram_addr;
    logic        bram_en;
    logic [3:0]  bram_wen;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    logic [31:0] mem [0:63];

    int errors = 0;
    int checks = 0;

    always #5 ap_clk = ~ap_clk;

    romcode_bram_arb #(.MAX_WAIT(8), .WAIT_W(4)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .rom_lock  (rom_lock),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_wen  (bram_wen),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    // Read-first single-port BRAM with byte write enables.
    always @(posedge ap_clk) begin
        if (bram_en) begin
            bram_dout <= mem[bram_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (bram_wen[b]) mem[bram_addr[7:2]][8*b +: 8] <= bram_din[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        rd_req   = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        wr_strb  = strb;
        #1 chk("wr_ready_idle", {31'b0, wr_ready}, 32'd1);
        @(negedge ap_clk);
        wr_valid = 1'b0;
        chk("wr_bram_en", {31'b0, bram_en}, (strb != 4'd0) ? 32'd1 : 32'd0);
        chk("wr_bram_wen", {28'b0, bram_wen}, {28'b0, strb});
        @(negedge ap_clk);
    endtask

    // Starts and ends on a falling edge; checks the 2-cycle accept-to-rvalid latency.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        rd_req  = 1'b1;
        rd_addr = addr;
        #1 chk("rd_gnt", {31'b0, rd_gnt}, 32'd1);
        @(negedge ap_clk);
        rd_req = 1'b0;
        chk("rd_bram_addr", bram_addr, exp_addr);
        chk("rd_bram_en", {31'b0, bram_en}, 32'd1);
        chk("rd_bram_wen", {28'b0, bram_wen}, 32'd0);
        chk("rd_rvalid_c1", {31'b0, rd_rvalid}, 32'd0);
        @(negedge ap_clk);
        chk("rd_rvalid_c2", {31'b0, rd_rvalid}, 32'd0);
        @(negedge ap_clk);
        chk("rd_rvalid_c3", {31'b0, rd_rvalid}, 32'd1);
        chk("rd_rdata", rd_rdata, exp_data);
        @(negedge ap_clk);
        chk("rd_rvalid_c4", {31'b0, rd_rvalid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        bram_dout = 32'h0;
        ap_rst_n  = 1'b0;
        rd_req    = 1'b1;
        rd_addr   = 32'h0;
        wr_valid  = 1'b1;
        wr_addr   = 32'h0;
        wr_data   = 32'h0;
        wr_strb   = 4'h0;
        rom_lock  = 1'b0;

        // Reset state, with requests asserted to prove grants are masked.
        #2;
        chk("rst_rd_gnt", {31'b0, rd_gnt}, 32'd0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("rst_bram_en", {31'b0, bram_en}, 32'd0);
        chk("rst_bram_addr", bram_addr, 32'd0);
        chk("rst_rvalid", {31'b0, rd_rvalid}, 32'd0);
        chk("rst_rdata", rd_rdata, 32'd0);
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Single read with unaligned address.
        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        do_read(32'h13, 32'h10, 32'hDEADBEEF);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) do_write(32'(4 * i), 32'(i + 1), 4'hF);
        rd_req  = 1'b1;
        rd_addr = 32'h0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge ap_clk);
            chk("b2b_bram_en", {31'b0, bram_en}, (k <= 4) ? 32'd1 : 32'd0);
            if (k <= 4) chk("b2b_bram_addr", bram_addr, 32'(4 * (k - 1)));
            chk("b2b_rvalid", {31'b0, rd_rvalid}, (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
            if (k >= 3 && k <= 6) chk("b2b_rdata", rd_rdata, 32'(k - 2));
            if (k < 4) rd_addr = 32'(4 * k);
            else rd_req = 1'b0;
        end
        @(negedge ap_clk);

        // Starvation bound: 8 refusals, then a forced write slot.
        rd_req   = 1'b1;
        rd_addr  = 32'h0;
        wr_valid = 1'b1;
        wr_addr  = 32'h20;
        wr_data  = 32'hCAFEF00D;
        wr_strb  = 4'hF;
        for (int c = 0; c <= 8; c++) begin
            #1;
            chk("starve_wr_ready", {31'b0, wr_ready}, (c == 8) ? 32'd1 : 32'd0);
            chk("starve_rd_gnt", {31'b0, rd_gnt}, (c == 8) ? 32'd0 : 32'd1);
            chk("starve_wait_cnt", 32'(dut.wait_cnt_q), 32'(c));
            @(negedge ap_clk);
        end
        wr_valid = 1'b0;
        chk("forced_bram_en", {31'b0, bram_en}, 32'd1);
        chk("forced_bram_wen", {28'b0, bram_wen}, 32'hF);
        chk("forced_bram_addr", bram_addr, 32'h20);
        chk("forced_bram_din", bram_din, 32'hCAFEF00D);
        chk("forced_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
        chk("forced_last_gnt", 32'(dut.last_gnt_q), 32'(G_WR));
        #1 chk("resume_rd_gnt", {31'b0, rd_gnt}, 32'd1);
        @(negedge ap_clk);
        chk("resume_bram_en", {31'b0, bram_en}, 32'd1);
        chk("resume_bram_wen", {28'b0, bram_wen}, 32'd0);
        chk("resume_last_gnt", 32'(dut.last_gnt_q), 32'(G_RD));
        rd_req = 1'b0;
        repeat (4) @(negedge ap_clk);
        do_read(32'h20, 32'h20, 32'hCAFEF00D);

        // Partial writes, including an all-zero strobe.
        do_write(32'h30, 32'h11223344, 4'hF);
        do_write(32'h30, 32'hAABBCCDD, 4'b0101);
        do_read(32'h30, 32'h30, 32'h11BB33DD);
        do_write(32'h30, 32'hFFFFFFFF, 4'h0);
        do_read(32'h30, 32'h30, 32'h11BB33DD);

        // rom_lock blocks writes, reads still flow, no forced slot.
        rom_lock = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 32'h34;
        wr_data  = 32'h0BADF00D;
        wr_strb  = 4'hF;
        for (int c = 0; c < 20; c++) begin
            rd_req  = (c % 2 == 1);
            rd_addr = 32'h0;
            #1;
            chk("lock_wr_ready", {31'b0, wr_ready}, 32'd0);
            chk("lock_rd_gnt", {31'b0, rd_gnt}, (c % 2 == 1) ? 32'd1 : 32'd0);
            chk("lock_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
            @(negedge ap_clk);
        end
        rom_lock = 1'b0;
        rd_req   = 1'b0;
        #1 chk("unlock_wr_ready", {31'b0, wr_ready}, 32'd1);
        @(negedge ap_clk);
        wr_valid = 1'b0;
        chk("unlock_bram_wen", {28'b0, bram_wen}, 32'hF);
        chk("unlock_bram_addr", bram_addr, 32'h34);
        repeat (4) @(negedge ap_clk);
        do_read(32'h34, 32'h34, 32'h0BADF00D);

        // Async reset between accept and data return.
        rd_req  = 1'b1;
        rd_addr = 32'h10;
        @(negedge ap_clk);
        rd_req = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_bram_en", {31'b0, bram_en}, 32'd0);
        chk("mid_rst_bram_addr", bram_addr, 32'd0);
        chk("mid_rst_bram_wen", {28'b0, bram_wen}, 32'd0);
        chk("mid_rst_bram_din", bram_din, 32'd0);
        chk("mid_rst_rvalid", {31'b0, rd_rvalid}, 32'd0);
        chk("mid_rst_rdata", rd_rdata, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge ap_clk);
            chk("in_rst_rvalid", {31'b0, rd_rvalid}, 32'd0);
        end
        ap_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge ap_clk);
            chk("post_rst_rvalid", {31'b0, rd_rvalid}, 32'd0);
        end
        do_read(32'h13, 32'h10, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
